// File: rtl/mod_pkg.sv
// Shared definitions for the modular exponentiation slice: widths, the P-192
// prime used with mod_mul, and the sequencer state encoding.
package mod_pkg;

    localparam int WIDTH     = 192;
    localparam int EXP_WIDTH = 192;

    localparam logic [191:0] P192 = 192'hfffffffffffffffffffffffffffffffeffffffffffffffff;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        NEXT,
        SQR,
        MGAP,
        MUL,
        DONE
    } state_t;

endpackage

// File: rtl/mod_exp_ctrl_if.sv
// Request/result handshake plus the operand/product bus toward mod_mul.
// master = requester and multiplier side, slave = the exponentiation sequencer.
interface mod_exp_ctrl_if #(
    parameter int WIDTH     = mod_pkg::WIDTH,
    parameter int EXP_WIDTH = mod_pkg::EXP_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     base;
    logic [EXP_WIDTH-1:0] exponent;
    logic                 busy;
    logic                 done;
    logic [WIDTH-1:0]     result;
    logic [WIDTH-1:0]     mm_x;
    logic [WIDTH-1:0]     mm_y;
    logic                 mm_start;
    logic [WIDTH-1:0]     mm_z;
    logic                 mm_done;

    modport master (
        output start, base, exponent, mm_z, mm_done,
        input  busy, done, result, mm_x, mm_y, mm_start
    );

    modport slave (
        input  start, base, exponent, mm_z, mm_done,
        output busy, done, result, mm_x, mm_y, mm_start
    );
endinterface

// File: rtl/mod_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving an external mod_mul.
// state | meaning
// IDLE  | waiting for start
// SCAN  | skipping leading exponent zeros, one bit per cycle
// NEXT  | issue a squaring, or finish when bits are exhausted
// SQR   | squaring in flight
// MGAP  | gap cycle, then issue multiply by base
// MUL   | multiply in flight
// DONE  | done pulse cycle, busy drops on exit
module mod_exp_ctrl
    import mod_pkg::*;
#(
    parameter int WIDTH     = mod_pkg::WIDTH,
    parameter int EXP_WIDTH = mod_pkg::EXP_WIDTH
) (
    input logic           clk,
    input logic           rst,
    mod_exp_ctrl_if.slave bus
);

    localparam int CW = $clog2(EXP_WIDTH + 1);

    state_t               state, state_nxt;
    logic [EXP_WIDTH-1:0] e_reg, e_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [WIDTH-1:0]     acc, acc_nxt;
    logic [WIDTH-1:0]     base_reg, base_nxt;
    logic [WIDTH-1:0]     result_q, result_nxt;
    logic [WIDTH-1:0]     mm_x_q, mm_x_nxt;
    logic [WIDTH-1:0]     mm_y_q, mm_y_nxt;
    logic                 busy_q, busy_nxt;
    logic                 done_q, done_nxt;
    logic                 mm_start_q, mm_start_nxt;

    logic                 e_msb;
    logic [EXP_WIDTH-1:0] e_shl;

    assign e_msb = e_reg[EXP_WIDTH-1];
    assign e_shl = {e_reg[EXP_WIDTH-2:0], 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            e_reg      <= '0;
            cnt        <= '0;
            acc        <= '0;
            base_reg   <= '0;
            result_q   <= '0;
            mm_x_q     <= '0;
            mm_y_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mm_start_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            e_reg      <= e_nxt;
            cnt        <= cnt_nxt;
            acc        <= acc_nxt;
            base_reg   <= base_nxt;
            result_q   <= result_nxt;
            mm_x_q     <= mm_x_nxt;
            mm_y_q     <= mm_y_nxt;
            busy_q     <= busy_nxt;
            done_q     <= done_nxt;
            mm_start_q <= mm_start_nxt;
        end
    end

    // done/result are registered on the edge entering DONE, so the pulse is
    // visible during the DONE cycle and busy falls on the edge leaving it.
    always_comb begin
        state_nxt    = state;
        e_nxt        = e_reg;
        cnt_nxt      = cnt;
        acc_nxt      = acc;
        base_nxt     = base_reg;
        result_nxt   = result_q;
        mm_x_nxt     = mm_x_q;
        mm_y_nxt     = mm_y_q;
        busy_nxt     = busy_q;
        done_nxt     = 1'b0;
        mm_start_nxt = mm_start_q;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    base_nxt  = bus.base;
                    e_nxt     = bus.exponent;
                    cnt_nxt   = CW'(EXP_WIDTH);
                    busy_nxt  = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (cnt == '0) begin
                    acc_nxt    = WIDTH'(1);
                    result_nxt = WIDTH'(1);
                    done_nxt   = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    if (e_msb) begin
                        acc_nxt   = base_reg;
                        state_nxt = NEXT;
                    end
                    e_nxt   = e_shl;
                    cnt_nxt = cnt - CW'(1);
                end
            end
            NEXT: begin
                if (cnt == '0) begin
                    result_nxt = acc;
                    done_nxt   = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    mm_x_nxt     = acc;
                    mm_y_nxt     = acc;
                    mm_start_nxt = 1'b1;
                    state_nxt    = SQR;
                end
            end
            SQR: begin
                if (bus.mm_done) begin
                    acc_nxt      = bus.mm_z;
                    mm_start_nxt = 1'b0;
                    if (e_msb) begin
                        state_nxt = MGAP;
                    end else begin
                        e_nxt     = e_shl;
                        cnt_nxt   = cnt - CW'(1);
                        state_nxt = NEXT;
                    end
                end
            end
            MGAP: begin
                mm_x_nxt     = acc;
                mm_y_nxt     = base_reg;
                mm_start_nxt = 1'b1;
                state_nxt    = MUL;
            end
            MUL: begin
                if (bus.mm_done) begin
                    acc_nxt      = bus.mm_z;
                    mm_start_nxt = 1'b0;
                    e_nxt        = e_shl;
                    cnt_nxt      = cnt - CW'(1);
                    state_nxt    = NEXT;
                end
            end
            DONE: begin
                busy_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.mm_x     = mm_x_q;
    assign bus.mm_y     = mm_y_q;
    assign bus.mm_start = mm_start_q;

endmodule
